shift_reg_univ: RTL and testbench

//  Parametrised universal shift register: load, hold, logical shifts, rotates and

---
 rtl/shift_reg_univ_if.sv | 29 ++
 rtl/shift_reg_univ.sv | 108 ++++++++++
 tb/tb_shift_reg_univ.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_univ_if.sv
// Bus bundle for the universal shift register: control, data and status.
// The master side drives the controls; the slave side is the register itself.
interface shift_reg_univ_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             en;
  logic [2:0]       s;
  logic             sdl;
  logic             sdr;
  logic [WIDTH-1:0] d;
  logic             start;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q;
  logic             sol;
  logic             sor;
  logic             busy;
  logic             done;

  modport master (
    output en, s, sdl, sdr, d, start, cnt,
    input  q, sol, sor, busy, done
  );

  modport slave (
    input  en, s, sdl, sdr, d, start, cnt,
    output q, sol, sor, busy, done
  );
endinterface

// File: rtl/shift_reg_univ.sv
// Universal shift register: direct load/hold/shift/rotate/asr ops, plus a
// sequenced mode where one START repeats a shift/rotate op CNT times with a
// BUSY/DONE handshake. Serial ends are exposed for chaining.
module shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic            clk,
  input logic            rst,
  shift_reg_univ_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  // One step of the selected operation; load and hold/reserved fall through here too.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       mode,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] din,
    input logic             sdl,
    input logic             sdr
  );
    logic [WIDTH-1:0] res;
    res = cur;
    case (mode)
      3'b001:  res = {sdr, cur[WIDTH-1:1]};
      3'b010:  res = {cur[WIDTH-2:0], sdl};
      3'b011:  res = din;
      3'b100:  res = {cur[0], cur[WIDTH-1:1]};
      3'b101:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b110:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: res = cur;
    endcase
    return res;
  endfunction

  // Only shifts and rotates may be sequenced; load/hold/reserved act directly.
  function automatic logic is_shift(input logic [2:0] mode);
    return (mode == 3'b001) || (mode == 3'b010) || (mode == 3'b100) ||
           (mode == 3'b101) || (mode == 3'b110);
  endfunction

  // State, data, latched mode and remaining-step count all clear immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      mode_q  <= 3'b000;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state and datapath: direct ops in IDLE, one latched step per cycle in RUN,
  // FIN is a one-cycle completion state where every input is ignored.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          if (bus.start && is_shift(bus.s)) begin
            mode_d  = bus.s;
            rem_d   = bus.cnt;
            state_d = (bus.cnt != '0) ? RUN : FIN;
          end else begin
            q_d = apply_op(bus.s, q_q, bus.d, bus.sdl, bus.sdr);
          end
        end
      end
      RUN: begin
        q_d   = apply_op(mode_q, q_q, bus.d, bus.sdl, bus.sdr);
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.q    = q_q;
  assign bus.sol  = q_q[WIDTH-1];
  assign bus.sor  = q_q[0];
  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == FIN);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ: an 8-bit and a 16-bit instance. Stimulus
// pushes expected results; per-instance monitors pop on DONE or on a check request.
module tb_shift_reg_univ;

  logic clk = 1'b0;
  logic rst8;
  logic rst16;

  always #5 clk = ~clk;

  shift_reg_univ_if #(.WIDTH(8),  .CNT_W(4)) a8 ();
  shift_reg_univ_if #(.WIDTH(16), .CNT_W(5)) a16 ();

  shift_reg_univ #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (a8)
  );

  shift_reg_univ #(.WIDTH(16), .CNT_W(5)) dut16 (
    .clk (clk),
    .rst (rst16),
    .bus (a16)
  );

  typedef struct {
    string       name;
    logic [15:0] q;
    int          busy_len;
    bit          is_done;
  } exp_t;

  exp_t exp8_q[$];
  exp_t exp16_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   req8  = 1'b0;
  bit   req16 = 1'b0;
  int   busy_cnt8  = 0;
  int   busy_cnt16 = 0;

  task automatic compare(input string name, input string field,
                         input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=%h expected=%h", name, field, act, expv);
    end
  endtask

  // Monitor for the 8-bit instance: counts BUSY cycles and checks each presented result.
  always @(negedge clk) begin
    exp_t e;
    if (rst8) busy_cnt8 = 0;
    else if (a8.busy) busy_cnt8++;
    if (a8.done || req8) begin
      if (exp8_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected8 actual=done:%0b q=%h expected=no output", a8.done, a8.q);
      end else begin
        e = exp8_q.pop_front();
        compare(e.name, "q",    16'(a8.q),    e.q);
        compare(e.name, "sol",  16'(a8.sol),  16'(e.q[7]));
        compare(e.name, "sor",  16'(a8.sor),  16'(e.q[0]));
        compare(e.name, "done", 16'(a8.done), 16'(e.is_done));
        compare(e.name, "busy", 16'(a8.busy), 16'(0));
        if (e.is_done) begin
          compare(e.name, "busyLen", 16'(busy_cnt8), 16'(e.busy_len));
          busy_cnt8 = 0;
        end
      end
    end
  end

  // Monitor for the 16-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst16) busy_cnt16 = 0;
    else if (a16.busy) busy_cnt16++;
    if (a16.done || req16) begin
      if (exp16_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected16 actual=done:%0b q=%h expected=no output", a16.done, a16.q);
      end else begin
        e = exp16_q.pop_front();
        compare(e.name, "q",    a16.q,         e.q);
        compare(e.name, "sol",  16'(a16.sol),  16'(e.q[15]));
        compare(e.name, "sor",  16'(a16.sor),  16'(e.q[0]));
        compare(e.name, "done", 16'(a16.done), 16'(e.is_done));
        compare(e.name, "busy", 16'(a16.busy), 16'(0));
        if (e.is_done) begin
          compare(e.name, "busyLen", 16'(busy_cnt16), 16'(e.busy_len));
          busy_cnt16 = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push8(input string name, input logic [15:0] q, input int len, input bit is_done);
    exp_t e;
    e.name = name; e.q = q; e.busy_len = len; e.is_done = is_done;
    exp8_q.push_back(e);
  endtask

  task automatic push16(input string name, input logic [15:0] q, input int len, input bit is_done);
    exp_t e;
    e.name = name; e.q = q; e.busy_len = len; e.is_done = is_done;
    exp16_q.push_back(e);
  endtask

  // Drive one edge's worth of inputs; en/start drop afterwards, serial/data stay.
  task automatic applyStimulus8(input logic en, input logic [2:0] s, input logic [7:0] d,
                                input logic sdl, input logic sdr, input logic start,
                                input logic [3:0] cnt);
    a8.en = en; a8.s = s; a8.d = d; a8.sdl = sdl; a8.sdr = sdr;
    a8.start = start; a8.cnt = cnt;
    step();
    a8.en = 1'b0; a8.start = 1'b0;
  endtask

  task automatic applyStimulus16(input logic en, input logic [2:0] s, input logic [15:0] d,
                                 input logic sdl, input logic sdr, input logic start,
                                 input logic [4:0] cnt);
    a16.en = en; a16.s = s; a16.d = d; a16.sdl = sdl; a16.sdr = sdr;
    a16.start = start; a16.cnt = cnt;
    step();
    a16.en = 1'b0; a16.start = 1'b0;
  endtask

  task automatic checkOutput8(input string name, input logic [7:0] q);
    push8(name, 16'(q), 0, 1'b0);
    req8 = 1'b1;
    step();
    req8 = 1'b0;
  endtask

  task automatic checkOutput16(input string name, input logic [15:0] q);
    push16(name, q, 0, 1'b0);
    req16 = 1'b1;
    step();
    req16 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst8 = 1'b1; rst16 = 1'b1;
    a8.en = 0; a8.s = 0; a8.d = 0; a8.sdl = 0; a8.sdr = 0; a8.start = 0; a8.cnt = 0;
    a16.en = 0; a16.s = 0; a16.d = 0; a16.sdl = 0; a16.sdr = 0; a16.start = 0; a16.cnt = 0;
    repeat (2) step();
    rst8 = 1'b0; rst16 = 1'b0;

    checkOutput8("reset8", 8'h00);
    checkOutput16("reset16", 16'h0000);

    // Asynchronous clear without any clock edge after a load.
    applyStimulus8(1, 3'b011, 8'hA5, 0, 0, 0, 0);
    checkOutput8("loadA5", 8'hA5);
    push8("asyncClr", 16'h0000, 0, 1'b0);
    req8 = 1'b1;
    #2 rst8 = 1'b1;
    @(negedge clk);
    #1 rst8 = 1'b0;
    step();
    req8 = 1'b0;

    // Direct operations.
    applyStimulus8(1, 3'b011, 8'h81, 0, 0, 0, 0);
    applyStimulus8(1, 3'b010, 8'h00, 1, 0, 0, 0);
    checkOutput8("shl", 8'h03);
    applyStimulus8(1, 3'b001, 8'h00, 0, 0, 0, 0);
    checkOutput8("shr", 8'h01);
    applyStimulus8(1, 3'b001, 8'h00, 0, 1, 0, 0);
    checkOutput8("shrSdr1", 8'h80);
    applyStimulus8(1, 3'b110, 8'h00, 0, 0, 0, 0);
    checkOutput8("asr1", 8'hC0);
    applyStimulus8(1, 3'b000, 8'hFF, 1, 1, 0, 0);
    checkOutput8("hold", 8'hC0);
    applyStimulus8(1, 3'b111, 8'hFF, 1, 1, 0, 0);
    checkOutput8("reserved", 8'hC0);
    applyStimulus8(0, 3'b011, 8'hFF, 0, 0, 0, 0);
    checkOutput8("enOff", 8'hC0);
    applyStimulus8(0, 3'b100, 8'h00, 0, 0, 1, 4'd3);
    checkOutput8("startNoEn", 8'hC0);
    applyStimulus8(1, 3'b011, 8'h3C, 0, 0, 1, 4'd5);
    checkOutput8("startLoad", 8'h3C);
    applyStimulus8(1, 3'b101, 8'h00, 0, 0, 0, 0);
    checkOutput8("rol1", 8'h78);

    // Sequenced ror x3 from 81.
    applyStimulus8(1, 3'b011, 8'h81, 0, 0, 0, 0);
    push8("ror3", 16'h0030, 3, 1'b1);
    applyStimulus8(1, 3'b100, 8'h00, 0, 0, 1, 4'd3);
    repeat (5) step();

    // asr x7 from 80 saturates to all-ones.
    applyStimulus8(1, 3'b011, 8'h80, 0, 0, 0, 0);
    push8("asr7", 16'h00FF, 7, 1'b1);
    applyStimulus8(1, 3'b110, 8'h00, 0, 0, 1, 4'd7);
    repeat (9) step();

    // rol x9 wraps; load/start pressure during RUN and FIN must be ignored.
    applyStimulus8(1, 3'b011, 8'h80, 0, 0, 0, 0);
    push8("rol9", 16'h0001, 9, 1'b1);
    applyStimulus8(1, 3'b101, 8'h00, 0, 0, 1, 4'd9);
    a8.en = 1; a8.s = 3'b011; a8.d = 8'hFF; a8.start = 1; a8.cnt = 4'd2;
    repeat (10) step();
    a8.en = 0; a8.start = 0; a8.s = 3'b000;
    checkOutput8("afterJunk", 8'h01);

    // Zero-count start: no BUSY, DONE next cycle, Q untouched.
    push8("cnt0", 16'h0001, 0, 1'b1);
    applyStimulus8(1, 3'b001, 8'h00, 0, 1, 1, 4'd0);
    repeat (2) step();

    // Count beyond width flushes the serial input through.
    push8("shrFlush", 16'h00FF, 10, 1'b1);
    applyStimulus8(1, 3'b001, 8'h00, 0, 1, 1, 4'd10);
    repeat (12) step();
    checkOutput8("flushHold", 8'hFF);

    // 16-bit instance: shl x17 clears the word.
    applyStimulus16(1, 3'b011, 16'h8001, 0, 0, 0, 0);
    checkOutput16("load8001", 16'h8001);
    push16("shl17", 16'h0000, 17, 1'b1);
    applyStimulus16(1, 3'b010, 16'h0000, 0, 0, 1, 5'd17);
    repeat (19) step();

    // Clear during step 5 of a run aborts it with no DONE.
    applyStimulus16(1, 3'b011, 16'h8001, 0, 0, 0, 0);
    applyStimulus16(1, 3'b010, 16'h0000, 0, 0, 1, 5'd17);
    repeat (4) step();
    #2 rst16 = 1'b1;
    @(negedge clk);
    #1 rst16 = 1'b0;
    repeat (20) step();
    checkOutput16("abortClr", 16'h0000);
    applyStimulus16(1, 3'b011, 16'h1234, 0, 0, 0, 0);
    checkOutput16("postAbortLoad", 16'h1234);

    repeat (2) step();
    checks++;
    if (exp8_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending8 actual=%0d expected=0", exp8_q.size());
    end
    checks++;
    if (exp16_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending16 actual=%0d expected=0", exp16_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
